// File: rtl/minmax_pkg.sv
`default_nettype none
// ============================================================================
// Module   : minmax_pkg
// Purpose  : Shared definitions for the frame_minmax statistics stage:
//            FSM state encoding and default datapath widths.
// Revision : 1.0 - initial release
// ============================================================================
package minmax_pkg;

  // Default sample width and per-frame beat counter width.
  localparam int DEF_W     = 4;
  localparam int DEF_CNT_W = 8;

  // Frame FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // waiting for the first beat of a frame
    ST_ACCUM = 2'd1,  // inside a frame, accumulating extremes
    ST_HOLD  = 2'd2   // result presented, waiting for the consumer
  } state_t;

endpackage : minmax_pkg
`default_nettype wire

// File: rtl/minmax_cmp.sv
`default_nettype none
// ============================================================================
// Module   : minmax_cmp
// Purpose  : Purely combinational unsigned max/min of two samples.
// Ports    : a, b [W-1:0] - operands (unsigned)
//            max  [W-1:0] - larger of a and b
//            min  [W-1:0] - smaller of a and b
// Revision : 1.0 - initial release
// ============================================================================
module minmax_cmp #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] max,
  output logic [W-1:0] min
);

  assign max = (a > b) ? a : b;
  assign min = (a < b) ? a : b;

endmodule : minmax_cmp
`default_nettype wire

// File: rtl/frame_minmax.sv
`default_nettype none
// ============================================================================
// Module   : frame_minmax
// Purpose  : Streaming per-frame maximum/minimum. Consumes a valid/ready
//            stream of unsigned W-bit samples delimited by s_last and emits
//            one result beat per frame on a valid/ready output.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            s_valid/s_ready     - input handshake
//            s_data [W-1:0]      - input sample
//            s_last              - final sample of a frame
//            m_valid/m_ready     - result handshake
//            m_max/m_min [W-1:0] - frame extremes
//            m_count [CNT_W-1:0] - beats in frame (FRAME_MINMAX_COUNT_EN only)
// Config   : FRAME_MINMAX_COUNT_EN - adds the saturating beat counter and
//            the m_count port.
// Revision : 1.0 - initial release
// ============================================================================
module frame_minmax
  import minmax_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [W-1:0]     s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [W-1:0]     m_max,
`ifdef FRAME_MINMAX_COUNT_EN
  output logic [CNT_W-1:0] m_count,
`endif
  output logic [W-1:0]     m_min
);

  state_t         state_q,   state_d;
  logic [W-1:0]   acc_max_q, acc_max_d;
  logic [W-1:0]   acc_min_q, acc_min_d;
  logic [W-1:0]   m_max_q,   m_max_d;
  logic [W-1:0]   m_min_q,   m_min_d;
  logic           m_valid_q, m_valid_d;

  logic [W-1:0]   cmp_a_max;
  logic [W-1:0]   cmp_a_min;
  logic [W-1:0]   cmp_max;
  logic [W-1:0]   cmp_min;
  logic           beat_acc;
  logic           first_beat;

  // Ready depends only on the state register: no path from s_valid/m_ready.
  assign s_ready    = (state_q != ST_HOLD);
  assign beat_acc   = s_valid && s_ready;
  assign first_beat = (state_q == ST_IDLE);

  // On the first beat of a frame the accumulators hold stale data, so the
  // comparator sees the sample on both inputs and returns it as max and min.
  assign cmp_a_max = first_beat ? s_data : acc_max_q;
  assign cmp_a_min = first_beat ? s_data : acc_min_q;

  // The max and min accumulators diverge after the first beat, so each
  // path needs its own comparator operand; the unused half of each
  // instance is left to synthesis to trim.
  logic [W-1:0] unused_min_of_max;
  logic [W-1:0] unused_max_of_min;

  minmax_cmp #(.W(W)) u_cmp_max (
    .a   (cmp_a_max),
    .b   (s_data),
    .max (cmp_max),
    .min (unused_min_of_max)
  );

  minmax_cmp #(.W(W)) u_cmp_min (
    .a   (cmp_a_min),
    .b   (s_data),
    .max (unused_max_of_min),
    .min (cmp_min)
  );

  // --------------------------------------------------------------------------
  // Next-state / datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    acc_max_d = acc_max_q;
    acc_min_d = acc_min_q;
    m_max_d   = m_max_q;
    m_min_d   = m_min_q;
    m_valid_d = m_valid_q;

    unique case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (beat_acc) begin
          acc_max_d = cmp_max;
          acc_min_d = cmp_min;
          if (s_last) begin
            m_max_d   = cmp_max;
            m_min_d   = cmp_min;
            m_valid_d = 1'b1;
            state_d   = ST_HOLD;
          end else begin
            state_d   = ST_ACCUM;
          end
        end
      end
      ST_HOLD: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        m_valid_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      acc_max_q <= '0;
      acc_min_q <= '0;
      m_max_q   <= '0;
      m_min_q   <= '0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_max_q <= acc_max_d;
      acc_min_q <= acc_min_d;
      m_max_q   <= m_max_d;
      m_min_q   <= m_min_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_max   = m_max_q;
  assign m_min   = m_min_q;

`ifdef FRAME_MINMAX_COUNT_EN
  // --------------------------------------------------------------------------
  // Saturating beat counter, latched alongside the extremes
  // --------------------------------------------------------------------------
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [CNT_W-1:0] m_count_q, m_count_d;
  logic [CNT_W-1:0] cnt_next;

  // First beat restarts at 1; later beats climb and stick at the maximum.
  assign cnt_next = first_beat          ? CNT_W'(1)
                  : (cnt_q == CNT_MAX)  ? cnt_q
                  :                       cnt_q + CNT_W'(1);

  always_comb begin
    cnt_d     = cnt_q;
    m_count_d = m_count_q;
    if (beat_acc) begin
      cnt_d = cnt_next;
      if (s_last) begin
        m_count_d = cnt_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      m_count_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      m_count_q <= m_count_d;
    end
  end

  assign m_count = m_count_q;
`endif

endmodule : frame_minmax
`default_nettype wire

// File: tb/tb_frame_minmax.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_minmax
// Purpose  : Directed self-checking bench for frame_minmax. Two instances
//            share the stimulus: dut (default CNT_W) and dut_s (CNT_W=2) so
//            counter saturation can be observed on the same frames.
// Config   : FRAME_MINMAX_COUNT_EN enables the m_count checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_minmax;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         s_valid;
  logic [W-1:0] s_data;
  logic         s_last;
  logic         m_ready;

  logic         s_ready,  s_ready_s;
  logic         m_valid,  m_valid_s;
  logic [W-1:0] m_max,    m_max_s;
  logic [W-1:0] m_min,    m_min_s;
`ifdef FRAME_MINMAX_COUNT_EN
  logic [7:0]   m_count;
  logic [1:0]   m_count_s;
`endif

  int n_checks = 0;
  int n_errors = 0;

  frame_minmax #(.W(W), .CNT_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_max   (m_max),
`ifdef FRAME_MINMAX_COUNT_EN
    .m_count (m_count),
`endif
    .m_min   (m_min)
  );

  frame_minmax #(.W(W), .CNT_W(2)) dut_s (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready_s),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid_s),
    .m_ready (m_ready),
    .m_max   (m_max_s),
`ifdef FRAME_MINMAX_COUNT_EN
    .m_count (m_count_s),
`endif
    .m_min   (m_min_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one beat from the negedge and hold it until accepted.
  task automatic send_beat(input logic [W-1:0] d, input logic last);
    int n;
    n = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("beat_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Checks taken #1 after the edge that accepted the last beat.
  task automatic check_result(input string tag, input logic [W-1:0] emax,
                              input logic [W-1:0] emin, input int ecnt);
    check({tag, "_valid"},   32'(m_valid), 32'd1);
    check({tag, "_sready"},  32'(s_ready), 32'd0);
    check({tag, "_max"},     32'(m_max),   32'(emax));
    check({tag, "_min"},     32'(m_min),   32'(emin));
    check({tag, "_max_s"},   32'(m_max_s), 32'(emax));
    check({tag, "_min_s"},   32'(m_min_s), 32'(emin));
`ifdef FRAME_MINMAX_COUNT_EN
    check({tag, "_cnt"},     32'(m_count),   32'(ecnt));
    check({tag, "_cnt_s"},   32'(m_count_s), 32'((ecnt > 3) ? 3 : ecnt));
`else
    if (ecnt < 0) check({tag, "_cnt_arg"}, 32'(ecnt), 32'd0);
`endif
  endtask

  // Let the result be taken, then confirm the one-cycle idle bubble.
  task automatic take_result(input string tag);
    @(negedge clk);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_taken_valid"},  32'(m_valid), 32'd0);
    check({tag, "_taken_sready"}, 32'(s_ready), 32'd1);
  endtask

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Reset state
    check("rst_valid",  32'(m_valid), 32'd0);
    check("rst_sready", 32'(s_ready), 32'd1);
    check("rst_max",    32'(m_max),   32'd0);
    check("rst_min",    32'(m_min),   32'd0);
`ifdef FRAME_MINMAX_COUNT_EN
    check("rst_cnt",    32'(m_count), 32'd0);
`endif

    // Frame 3,9,1,7 with m_ready already high: HOLD lasts one cycle.
    m_ready = 1'b1;
    send_beat(4'd3, 1'b0);
    check("f1_mid_valid", 32'(m_valid), 32'd0);
    send_beat(4'd9, 1'b0);
    send_beat(4'd1, 1'b0);
    send_beat(4'd7, 1'b1);
    check_result("f1", 4'd9, 4'd1, 4);
    @(posedge clk);
    #1;
    check("f1_hold_1cyc_sready", 32'(s_ready), 32'd1);
    check("f1_hold_1cyc_valid",  32'(m_valid), 32'd0);

    // Single-beat frame.
    send_beat(4'd5, 1'b1);
    check_result("f2", 4'd5, 4'd5, 1);
    @(posedge clk);
    #1;
    check("f2_done_valid", 32'(m_valid), 32'd0);

    // Frame 0,15 with the consumer stalled for 5 cycles.
    m_ready = 1'b0;
    send_beat(4'd0, 1'b0);
    send_beat(4'd15, 1'b1);
    check_result("f3", 4'd15, 4'd0, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("f3_stall_valid",  32'(m_valid), 32'd1);
      check("f3_stall_sready", 32'(s_ready), 32'd0);
      check("f3_stall_max",    32'(m_max),   32'd15);
      check("f3_stall_min",    32'(m_min),   32'd0);
    end
    take_result("f3");

    // Frame 6,6,6 with idle gaps between beats (data toggles while invalid).
    m_ready = 1'b0;
    send_beat(4'd6, 1'b0);
    for (int g = 0; g < 2; g++) begin
      @(negedge clk);
      s_data = 4'd15;
      s_last = 1'b1;
      check("f4_gap_valid", 32'(m_valid), 32'd0);
    end
    s_last = 1'b0;
    send_beat(4'd6, 1'b0);
    @(negedge clk);
    s_data = 4'd0;
    @(negedge clk);
    check("f4_gap2_valid", 32'(m_valid), 32'd0);
    send_beat(4'd6, 1'b1);
    check_result("f4", 4'd6, 4'd6, 3);
    take_result("f4");

    // Reset mid-frame discards the partial frame.
    send_beat(4'd2, 1'b0);
    send_beat(4'd8, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid",  32'(m_valid), 32'd0);
    check("rst_mid_sready", 32'(s_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_mid_no_valid", 32'(m_valid), 32'd0);
    end
    send_beat(4'd4, 1'b0);
    send_beat(4'd12, 1'b1);
    check_result("f5", 4'd12, 4'd4, 2);
    take_result("f5");

    // Six-beat frame: dut_s counter saturates at 3.
    m_ready = 1'b0;
    send_beat(4'd1,  1'b0);
    send_beat(4'd14, 1'b0);
    send_beat(4'd2,  1'b0);
    send_beat(4'd13, 1'b0);
    send_beat(4'd3,  1'b0);
    send_beat(4'd8,  1'b1);
    check_result("f6", 4'd14, 4'd1, 6);
    take_result("f6");

    // Reset while a result is pending discards it.
    send_beat(4'd10, 1'b1);
    check_result("f7", 4'd10, 4'd10, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_hold_valid", 32'(m_valid), 32'd0);
    check("rst_hold_max",   32'(m_max),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_hold_after_valid", 32'(m_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_frame_minmax
`default_nettype wire
